// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: request sequencer state and pending data-op encodings.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    HALT
  } ru_state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_READ,
    OP_WRITE
  } ru_op_t;

  // States in which a memory request is outstanding and the wait counter runs.
  function automatic logic ruIsActive(input ru_state_t s);
    return (s == FETCH) || (s == DATA);
  endfunction

endpackage

// File: rtl/ru_wait_counter.sv
// Saturating wait counter with synchronous clear and enable; flags when it sits at its limit.
module ru_wait_counter #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic atLimit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             atLimit;

  assign atLimit = (count_q == CNT_W'(TIMEOUT));

  // Clear wins over enable; a disabled counter is also forced to zero so it never carries stale counts.
  always_comb begin
    count_d = count_q;
    if (clear_i || !enable_i) begin
      count_d = '0;
    end else if (!atLimit) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign atLimit_o = atLimit;

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer: fetches an instruction, services at most one data access, then strobes pc_en.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic ihit,
  input  logic dhit,
  input  logic dren_req,
  input  logic dwen_req,
  input  logic halt_req,
  output logic imemREN,
  output logic dmemREN,
  output logic dmemWEN,
  output logic pc_en,
  output logic halted,
  output logic timeout
);

  ru_state_t state_q;
  ru_state_t state_d;
  ru_op_t    op_q;
  ru_op_t    op_d;
  logic      cntClear;
  logic      cntEnable;
  logic      atLimit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Only pc_en looks at the hit inputs combinationally; request outputs come from state and latched op.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    pc_en   = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (halt_req) begin
            state_d = HALT;
          end else if (dwen_req) begin
            op_d    = OP_WRITE;
            state_d = DATA;
          end else if (dren_req) begin
            op_d    = OP_READ;
            state_d = DATA;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        dmemWEN = (op_q == OP_WRITE);
        dmemREN = (op_q != OP_WRITE);
        if (dhit) begin
          pc_en   = 1'b1;
          op_d    = OP_NONE;
          state_d = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A request's wait restarts whenever the state changes or the hit it is waiting on arrives.
  assign cntEnable = ruIsActive(state_q);
  assign cntClear  = (state_d != state_q)
                   || ((state_q == FETCH) && ihit)
                   || ((state_q == DATA) && dhit);

  ru_wait_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_counter (
    .clk       (CLK),
    .rst       (RST),
    .clear_i   (cntClear),
    .enable_i  (cntEnable),
    .atLimit_o (atLimit)
  );

  assign timeout = atLimit && ruIsActive(state_q);

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: reference model feeds an expected-output queue each cycle.
module tb_request_unit;

  localparam int TO = 5;

  // Stimulus bit positions: {ihit, dhit, halt_req, dwen_req, dren_req}
  localparam logic [4:0] IH = 5'b10000;
  localparam logic [4:0] DH = 5'b01000;
  localparam logic [4:0] HR = 5'b00100;
  localparam logic [4:0] DW = 5'b00010;
  localparam logic [4:0] DR = 5'b00001;
  localparam logic [4:0] NO = 5'b00000;

  // Model states
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DATA  = 2;
  localparam int M_HALT  = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit = 1'b0;
  logic dhit = 1'b0;
  logic dren_req = 1'b0;
  logic dwen_req = 1'b0;
  logic halt_req = 1'b0;
  logic imemREN, dmemREN, dmemWEN, pc_en, halted, timeout;

  logic [5:0] outVec;
  assign outVec = {imemREN, dmemREN, dmemWEN, pc_en, halted, timeout};

  int checks = 0;
  int failures = 0;

  int mState = M_IDLE;
  int mCnt = 0;
  bit mWrite = 1'b0;

  logic [5:0] expQ[$];

  always #5 CLK = ~CLK;

  request_unit #(.TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ihit     (ihit),
    .dhit     (dhit),
    .dren_req (dren_req),
    .dwen_req (dwen_req),
    .halt_req (halt_req),
    .imemREN  (imemREN),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .pc_en    (pc_en),
    .halted   (halted),
    .timeout  (timeout)
  );

  function automatic logic [5:0] modelOut();
    logic im, dr, dw, pc, ht, tmo;
    im  = (mState == M_FETCH);
    dr  = (mState == M_DATA) && !mWrite;
    dw  = (mState == M_DATA) && mWrite;
    pc  = ((mState == M_FETCH) && ihit && !halt_req && !dwen_req && !dren_req)
       || ((mState == M_DATA) && dhit);
    ht  = (mState == M_HALT);
    tmo = ((mState == M_FETCH) || (mState == M_DATA)) && (mCnt == TO);
    return {im, dr, dw, pc, ht, tmo};
  endfunction

  task automatic modelReset();
    mState = M_IDLE;
    mCnt   = 0;
    mWrite = 1'b0;
  endtask

  task automatic advanceModel();
    int nxt;
    bit hit;
    nxt = mState;
    case (mState)
      M_IDLE:  nxt = M_FETCH;
      M_FETCH: begin
        if (ihit) begin
          if (halt_req) nxt = M_HALT;
          else if (dwen_req) begin nxt = M_DATA; mWrite = 1'b1; end
          else if (dren_req) begin nxt = M_DATA; mWrite = 1'b0; end
        end
      end
      M_DATA:  if (dhit) nxt = M_FETCH;
      default: nxt = M_HALT;
    endcase
    hit = ((mState == M_FETCH) && ihit) || ((mState == M_DATA) && dhit);
    if ((nxt != mState) || hit || !((mState == M_FETCH) || (mState == M_DATA))) mCnt = 0;
    else if (mCnt < TO) mCnt = mCnt + 1;
    mState = nxt;
  endtask

  // Drive one cycle of inputs on the falling edge and queue what the outputs must be.
  task automatic applyStimulus(input logic [4:0] v);
    @(negedge CLK);
    {ihit, dhit, halt_req, dwen_req, dren_req} = v;
    expQ.push_back(modelOut());
    #1;
  endtask

  task automatic applyReset();
    @(negedge CLK);
    RST = 1'b1;
    {ihit, dhit, halt_req, dwen_req, dren_req} = NO;
    modelReset();
    @(negedge CLK);
    RST = 1'b0;
    advanceModel();
  endtask

  task automatic test_reset();
    logic [5:0] expVec;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (outVec !== 6'b000000) begin
        failures++;
        $display("[TB] FAIL reset_hold[%0d] got=%b exp=%b", i, outVec, 6'b000000);
      end
    end
    modelReset();
    RST = 1'b0;
    expQ.push_back(modelOut());
    #1;
    expVec = expQ.pop_front();
    checks++;
    if (outVec !== expVec || outVec !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL reset_idle got=%b exp=%b", outVec, expVec);
    end
    advanceModel();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(NO);
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec || outVec !== 6'b100000) begin
        failures++;
        $display("[TB] FAIL reset_fetch[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
  endtask

  task automatic test_alu_stream();
    logic [5:0] expVec;
    int pcSeen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(IH);
      pcSeen += int'(pc_en);
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec) begin
        failures++;
        $display("[TB] FAIL alu[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
    checks++;
    if (pcSeen !== 4) begin
      failures++;
      $display("[TB] FAIL alu_pc_count got=%0d exp=4", pcSeen);
    end
  endtask

  task automatic test_load();
    logic [4:0] stim[6] = '{IH | DR, NO, NO, DH, NO, NO};
    logic [5:0] expVec;
    int pcSeen = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(stim[i]);
      pcSeen += int'(pc_en);
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec) begin
        failures++;
        $display("[TB] FAIL load[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
    checks++;
    if (pcSeen !== 1) begin
      failures++;
      $display("[TB] FAIL load_pc_count got=%0d exp=1", pcSeen);
    end
  endtask

  task automatic test_conflict();
    logic [4:0] stim[6] = '{IH | DR | DW, IH, IH | DR, NO, DH | IH, NO};
    logic [5:0] expVec;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(stim[i]);
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec) begin
        failures++;
        $display("[TB] FAIL conflict[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
  endtask

  task automatic test_timeout();
    logic [5:0] expVec;
    logic [4:0] v;
    // Fetch wait: 8 idle cycles, ihit, 2 idle; then a data wait of 8 cycles before dhit.
    for (int i = 0; i < 22; i++) begin
      if (i == 8) v = IH;
      else if (i == 11) v = IH | DW;
      else if (i == 20) v = DH;
      else v = NO;
      applyStimulus(v);
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec) begin
        failures++;
        $display("[TB] FAIL timeout[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] expVec;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(5'($urandom) & ~HR);
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
  endtask

  task automatic test_halt();
    logic [5:0] expVec;
    applyReset();
    for (int i = 0; i < 7; i++) begin
      if (i < 1) applyStimulus(NO);
      else if (i == 1) applyStimulus(IH | HR | DW);
      else applyStimulus(5'($urandom));
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec || (i > 1 && outVec !== 6'b000010)) begin
        failures++;
        $display("[TB] FAIL halt[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
  endtask

  task automatic test_reset_abort();
    logic [5:0] expVec;
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i == 1) ? (IH | DW) : NO);
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec) begin
        failures++;
        $display("[TB] FAIL abort_setup[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
    @(negedge CLK);
    {ihit, dhit, halt_req, dwen_req, dren_req} = DH;
    #1;
    RST = 1'b1;
    #1;
    checks++;
    if (outVec !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL abort_async got=%b exp=%b", outVec, 6'b000000);
    end
    modelReset();
    @(negedge CLK);
    checks++;
    if (outVec !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL abort_hold got=%b exp=%b", outVec, 6'b000000);
    end
    RST = 1'b0;
    {ihit, dhit, halt_req, dwen_req, dren_req} = NO;
    advanceModel();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(NO);
      expVec = expQ.pop_front();
      checks++;
      if (outVec !== expVec) begin
        failures++;
        $display("[TB] FAIL abort_recover[%0d] got=%b exp=%b", i, outVec, expVec);
      end
      advanceModel();
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_load();
    test_conflict();
    test_timeout();
    test_back_to_back();
    test_halt();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/request_unit.md
# request_unit

Sequential memory-request sequencer between the instruction decoder and the cache/memory interface. Takes the decoder's per-instruction memory intent (read, write, halt) and drives the single-ported memory handshake. It fetches an instruction, services at most one data access for that instruction, then enables the PC to advance. It sits in the datapath beside the control logic and replaces ad-hoc request/enable gating.

## Interface
Parameters:
- TIMEOUT, default 200: cycles a request may wait for its hit before `timeout` asserts.
- CNT_W, default $clog2(TIMEOUT+1): width of the wait counter.

Ports:
- CLK  in  1  system clock. Rising edge only.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction read complete; fetched word valid this cycle.
- dhit  in  1  data read/write complete this cycle.
- dren_req  in  1  decoded instruction is a load. Valid when ihit=1.
- dwen_req  in  1  decoded instruction is a store. Valid when ihit=1.
- halt_req  in  1  decoded instruction is HALT. Valid when ihit=1.
- imemREN  out  1  instruction read request.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- pc_en  out  1  one-cycle PC advance strobe.
- halted  out  1  sticky halt indicator.
- timeout  out  1  current request has waited ≥ TIMEOUT cycles.

## Operation
- State type ru_state_t has four states: IDLE, FETCH, DATA, HALT.
- RST asserted: state=IDLE, wait counter=0, op register=none. All outputs are 0.
- IDLE: all outputs 0. Moves unconditionally to FETCH on the next edge.
- FETCH: imemREN=1, dmemREN=dmemWEN=0. When ihit=1, priority is:
  - halt_req → HALT, pc_en=0.
  - dwen_req → latch op=WRITE, go to DATA, pc_en=0.
  - dren_req → latch op=READ, go to DATA, pc_en=0.
  - otherwise pc_en=1 (combinational, same cycle as ihit) and stay in FETCH.
- FETCH with ihit=0: stay in FETCH. dhit is ignored in FETCH.
- dren_req and dwen_req both 1: the write wins and the read is dropped. Not an error.
- DATA: imemREN=0. dmemWEN=1 if op=WRITE, else dmemREN=1 (registered, from the latched op). Never both.
  - On dhit: pc_en=1 (combinational, same cycle), op cleared, go to FETCH.
  - ihit is ignored in DATA.
- HALT: all requests 0, pc_en=0, halted=1. Only RST leaves HALT.
- Wait counter (CNT_W bits, unsigned):
  - Cleared on every state transition and on every cycle the relevant hit is 1.
  - Otherwise increments in FETCH or DATA, saturating at TIMEOUT (no wrap).
  - Holds 0 in IDLE and HALT.
- timeout = (counter == TIMEOUT) && state ∈ {FETCH, DATA}. Combinational from registered counter and state. Drops the cycle after the hit clears the counter.
- RST mid-request, from any state: immediate return to IDLE. The outstanding request is abandoned and no pc_en is issued.

## Timing
- pc_en is combinational: in FETCH from ihit, in DATA from dhit. No other outputs depend combinationally on inputs.
- Non-memory instruction: one pc_en per ihit. Minimum 1 cycle per instruction if ihit stays high.
- Load/store: minimum 2 cycles (ihit cycle, then dhit cycle). pc_en fires only in the dhit cycle.
- First imemREN=1 is exactly one cycle after RST deasserts (the IDLE cycle).
- HALT is entered on the edge after ihit with halt_req. halted=1 from that edge.

## Structure
- Add to cpu_types_pkg: typedef enum logic [1:0] ru_state_t {IDLE, FETCH, DATA, HALT}, and typedef enum logic [1:0] ru_op_t {OP_NONE, OP_READ, OP_WRITE}.
- One sub-module, ru_wait_counter: saturating counter with clear, enable, and an at-limit output. Parameterised by TIMEOUT and CNT_W.
- Top level contains the state register, op register, and output decode.

## Test plan
- Reset/idle: hold RST 3 cycles, release → all outputs 0 for 1 cycle, then imemREN=1 with pc_en=0 until ihit.
- ALU stream: ihit=1 for 4 consecutive cycles, no requests → pc_en=1 in all 4 cycles; dmemREN and dmemWEN stay 0.
- Load with 3-cycle latency: ihit with dren_req=1 → next cycle dmemREN=1, imemREN=0. dhit 3 cycles later → exactly one pc_en pulse in the dhit cycle, imemREN=1 the following cycle.
- Conflict plus stray hits: ihit with dren_req=dwen_req=1 → dmemWEN=1, dmemREN=0. Pulse ihit during DATA → no effect. dhit → FETCH.
- Timeout with TIMEOUT=5: in FETCH, hold ihit=0 → timeout rises on the 6th cycle and holds. ihit → counter clears, timeout=0 the next cycle.
- Halt and reset abort: ihit with halt_req=1 (and dwen_req=1) → HALT, halted=1, no data request. Separately, assert RST while in DATA → outputs 0 asynchronously, no pc_en.
